seq_squarer: RTL and testbench
==============================

# seq_squarer

Parametrised multi-cycle squarer/multiplier. It computes in_a², or in_a × in_b when in_mul is set, as a 2·WIDTH-bit result over WIDTH clock cycles using shift-and-add. It uses valid/ready handshakes on both the input and output sides. It sits in the arithmetic datapath as the clocked, width-generic successor to the team's fixed 4-bit combinational squarer, trading latency for area at larger widths.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32
- clk  input  1  rising-edge clock; the only clock in the block
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and mode are valid
- in_ready  output  1  block accepts operands this cycle
- in_a  input  WIDTH  operand A (unsigned)
- in_b  input  WIDTH  operand B (unsigned); ignored when in_mul=0
- in_mul  input  1  0 = square in_a; 1 = multiply in_a × in_b
- out_valid  output  1  result is valid and held
- out_ready  input  1  downstream accepts the result
- out_data  output  2·WIDTH  unsigned product

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: iterating; in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE→RUN on in_valid & in_ready.
  - Load mcand = zero-extended in_a into a 2·WIDTH register.
  - Load mplier = in_mul ? in_b : in_a.
  - Clear acc and cnt.
- Each RUN cycle:
  - If mplier[0], then acc ← acc + mcand.
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt + 1.
- RUN→DONE on the cycle in which cnt = WIDTH−1 completes its iteration, so exactly WIDTH iterations run.
- In DONE, out_data = acc, held stable until accepted.
- DONE→IDLE on out_ready. Changes to out_data while out_valid=1 and out_ready=0 are forbidden.
- Width and arithmetic rules:
  - All arithmetic is unsigned and modulo 2^(2·WIDTH).
  - Overflow is impossible because (2^WIDTH−1)² < 2^(2·WIDTH).
  - cnt is ⌈log2(WIDTH)⌉ bits wide; no wrap is reachable.
- Operands are sampled only at the accepting edge. in_a, in_b and in_mul may change freely afterwards with no effect.
- in_valid is ignored outside IDLE; no operand queuing.
- out_ready is ignored outside DONE.

## Timing
- Reset:
  - state=IDLE, acc=0, cnt=0.
  - out_valid=0, out_data=0.
  - in_ready=0 while rst=1; in_ready=1 in the first cycle after rst deasserts.
- Latency: with accept at edge k, out_valid is high in the cycle after edge k+WIDTH.
- Occupancy: minimum WIDTH+2 cycles per operation (accept, WIDTH iterations, handover).
- No back-to-back overlap: a new operand can be accepted no earlier than the cycle after the result handshake.
- Reset mid-operation, in RUN or DONE: the result is discarded and state returns to IDLE on the next edge. out_valid falls at that same edge with no result handshake.
- rst has priority over every handshake in the same cycle.
- in_ready and out_valid are decoded directly from state registers plus rst, with no combinational path from in_valid or out_ready.

## Structure
- Shared package square_pkg:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 recovers to IDLE.
  - a function clog2 for cnt width.
- One sub-module, square_step: a combinational single iteration.
  - Inputs: acc, mcand, mplier LSB.
  - Output: next acc.
  - Isolates the adder for reuse by a future unrolled variant.
- Top level holds the FSM, operand registers and handshake logic.

## Test plan
- WIDTH=4, square in_a=15 accepted at edge k → out_valid at cycle k+5, out_data=8'hE1 (225); in_ready low throughout.
- WIDTH=4, in_mul=1, in_a=13, in_b=11 → out_data=143. A second run with in_mul=0, in_a=13 and in_b=11 still present → 169 (in_b ignored).
- WIDTH=4, exhaustive squares of 0..15 with randomised out_ready and in_valid gaps → out_data=in_a² every time; 0 → 0, 1 → 1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid while pulsing in_valid with new operands → out_data stable, in_ready=0, the new operand is not taken; accept happens only after out_ready=1.
- Reset mid-RUN: assert rst for one cycle two edges after accept → out_valid never rises for that operation, in_ready=1 the cycle after reset; next operation in_a=7 → 49.
- WIDTH=8, in_a=255 squared → out_data=16'hFE01 (65025), out_valid exactly 8 cycles after accept.

Source files
------------

// File: rtl/square_pkg.sv
// Shared definitions for the sequential squarer: FSM state encoding and a
// constant-foldable ceiling-log2 used to size the iteration counter.
package square_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/square_step.sv
// One shift-and-add iteration: conditionally adds the shifted multiplicand
// into the accumulator. Kept separate so an unrolled variant can chain copies.
module square_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic               mplier_lsb,
  output logic [2*WIDTH-1:0] acc_next
);

  // Width is 2*WIDTH so the add is modulo 2^(2*WIDTH); the full square never overflows.
  assign acc_next = mplier_lsb ? (acc + mcand) : acc;

endmodule

// File: rtl/seq_squarer.sv
// Multi-cycle shift-and-add squarer/multiplier with valid/ready on both sides.
// One operand pair in flight at a time; WIDTH iterations per operation.
module seq_squarer
  import square_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mul,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  square_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier_lsb (mplier[0]),
    .acc_next   (acc_next)
  );

  // Handshake outputs depend only on state and rst, never on in_valid/out_ready.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign out_data  = acc;

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state  <= RUN;
            mcand  <= {{WIDTH{1'b0}}, in_a};
            mplier <= in_mul ? in_b : in_a;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == LAST_CNT) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        // NOTE: the unused encoding 2'd3 must fall back to IDLE rather than lock up.
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_squarer.sv
// Directed self-checking bench for seq_squarer at WIDTH=4 and WIDTH=8.
module tb_seq_squarer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid4, in_ready4, in_mul4, out_valid4, out_ready4;
  logic [3:0] in_a4, in_b4;
  logic [7:0] out_data4;

  logic        in_valid8, in_ready8, in_mul8, out_valid8, out_ready8;
  logic [7:0]  in_a8, in_b8;
  logic [15:0] out_data8;

  int vectors     = 0;
  int miscompares = 0;

  seq_squarer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_mul(in_mul4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
  );

  seq_squarer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_mul(in_mul8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one WIDTH=4 operation, check exact latency, hold it for `hold`
  // cycles of backpressure, then hand it off.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic mul,
                      input logic [7:0] exp, input string tag, input int hold);
    in_valid4 = 1'b1;
    in_a4 = a; in_b4 = b; in_mul4 = mul;
    check({tag, ".accept_ready"}, 32'(in_ready4), 32'd1);
    tick();
    in_valid4 = 1'b0;
    in_a4 = ~a; in_b4 = ~b; in_mul4 = ~mul;
    for (int i = 0; i < 4; i++) begin
      check({tag, ".run_hs"}, {30'd0, out_valid4, in_ready4}, 32'd0);
      tick();
    end
    check({tag, ".valid"}, 32'(out_valid4), 32'd1);
    check({tag, ".data"}, 32'(out_data4), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold"}, {22'd0, out_valid4, in_ready4, out_data4}, {22'd0, 2'b10, exp});
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check({tag, ".handoff"}, {30'd0, out_valid4, in_ready4}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_mul4 = 1'b0; out_ready4 = 1'b0;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_mul8 = 1'b0; out_ready8 = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst.in_ready", 32'(in_ready4), 32'd0);
    check("rst.out_valid", 32'(out_valid4), 32'd0);
    check("rst.out_data", 32'(out_data4), 32'd0);
    check("rst.out_data8", 32'(out_data8), 32'd0);
    rst = 1'b0;
    #1;
    check("rst.release_ready", 32'(in_ready4), 32'd1);

    // Basic square, multiply, and in_b ignored in square mode
    run4(4'd15, 4'd0, 1'b0, 8'hE1, "sq15", 0);
    run4(4'd13, 4'd11, 1'b1, 8'd143, "mul13x11", 1);
    run4(4'd13, 4'd11, 1'b0, 8'd169, "sq13_b_ignored", 0);

    // All squares with random idle gaps and random output backpressure
    for (int v = 0; v < 16; v++) begin
      int gap;
      logic [7:0] sq;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      sq = 8'(v * v);
      run4(4'(v), 4'($urandom), 1'b0, sq, "sq_sweep", $urandom_range(0, 3));
    end

    // Backpressure while new operands are offered
    in_valid4 = 1'b1; in_a4 = 4'd9; in_mul4 = 1'b0;
    tick();
    in_a4 = 4'd3;
    for (int i = 0; i < 4; i++) tick();
    check("bp.valid", 32'(out_valid4), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.hold", {22'd0, out_valid4, in_ready4, out_data4}, {22'd0, 2'b10, 8'd81});
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check("bp.after_hs_ready", {30'd0, out_valid4, in_ready4}, 32'd1);
    tick();
    in_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("bp.second_result", {23'd0, out_valid4, out_data4}, {23'd0, 1'b1, 8'd9});
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;

    // Reset two edges after accept: result is discarded
    in_valid4 = 1'b1; in_a4 = 4'd5; in_mul4 = 1'b0;
    tick();
    in_valid4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst.ready", {30'd0, out_valid4, in_ready4}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst.no_valid", 32'(out_valid4), 32'd0);
    end
    run4(4'd7, 4'd0, 1'b0, 8'd49, "sq7_after_rst", 0);

    // WIDTH=8 full-scale square, exactly 8 cycles of latency
    in_valid8 = 1'b1; in_a8 = 8'd255; in_mul8 = 1'b0;
    check("w8.accept_ready", 32'(in_ready8), 32'd1);
    tick();
    in_valid8 = 1'b0; in_a8 = 8'd0;
    for (int i = 0; i < 8; i++) begin
      check("w8.run_hs", {30'd0, out_valid8, in_ready8}, 32'd0);
      tick();
    end
    check("w8.result", {15'd0, out_valid8, out_data8}, {15'd0, 1'b1, 16'hFE01});
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("w8.handoff", {30'd0, out_valid8, in_ready8}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
